// File: rtl/zs_pkg.sv
// Shared constants and sideband type for the Zelen & Severo inverse-normal stage.
// Coefficients stay real here; to_fx quantises them at elaboration time.
package zs_pkg;

    localparam real C0 = 2.515517;
    localparam real C1 = 0.802853;
    localparam real C2 = 0.010328;
    localparam real D1 = 1.432788;
    localparam real D2 = 0.189269;
    localparam real D3 = 0.001308;

    localparam real T_LIMIT_REAL = 8.0;

    localparam int TAG_MAX = 32;

    typedef struct packed {
        logic               valid;
        logic               negate;
        logic [TAG_MAX-1:0] tag;
    } zs_sb_t;

    function automatic logic [63:0] to_fx(input real c, input int qfrac);
        real s;
        s = c;
        for (int i = 0; i < qfrac; i++) begin
            s = s * 2.0;
        end
        return longint'(s);
    endfunction

endpackage

// File: rtl/zs_div_pipe.sv
// Restoring unsigned divider computing (num << QFRAC) / den over DIV_LAT
// enabled stages, with valid and an opaque sideband travelling alongside.
module zs_div_pipe
    import zs_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int QFRAC   = 16,
    parameter int DIV_LAT = 4,
    parameter int SB_W    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [SB_W-1:0]  in_sb,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             out_valid,
    output logic [SB_W-1:0]  out_sb,
    output logic [WIDTH-1:0] out_quo
);

    localparam int BPS = (WIDTH + DIV_LAT - 1) / DIV_LAT;

    for (genvar s = 0; s < DIV_LAT; s++) begin : g_st
        logic             w_v_i;
        logic [SB_W-1:0]  w_sb_i;
        logic [WIDTH-1:0] w_rem_i;
        logic [WIDTH-1:0] w_q_i;
        logic [WIDTH-1:0] w_den_i;
        logic [WIDTH-1:0] w_rem_o;
        logic [WIDTH-1:0] w_q_o;

        logic             r_v;
        logic [SB_W-1:0]  r_sb;
        logic [WIDTH-1:0] r_rem;
        logic [WIDTH-1:0] r_q;
        logic [WIDTH-1:0] r_den;

        if (s == 0) begin : g_head
            // High QFRAC bits of num seed the remainder; the rest shift in.
            assign w_v_i   = in_valid;
            assign w_sb_i  = in_sb;
            assign w_den_i = in_den;
            assign w_rem_i = WIDTH'(in_num[WIDTH-1 -: QFRAC]);
            assign w_q_i   = {in_num[WIDTH-QFRAC-1:0], {QFRAC{1'b0}}};
        end else begin : g_tail
            assign w_v_i   = g_st[s-1].r_v;
            assign w_sb_i  = g_st[s-1].r_sb;
            assign w_den_i = g_st[s-1].r_den;
            assign w_rem_i = g_st[s-1].r_rem;
            assign w_q_i   = g_st[s-1].r_q;
        end

        always_comb begin
            logic [WIDTH:0] trial;
            trial   = '0;
            w_rem_o = w_rem_i;
            w_q_o   = w_q_i;
            for (int b = 0; b < BPS; b++) begin
                if (s * BPS + b < WIDTH) begin
                    trial = {w_rem_o, w_q_o[WIDTH-1]};
                    w_q_o = {w_q_o[WIDTH-2:0], 1'b0};
                    if (trial >= {1'b0, w_den_i}) begin
                        trial    = trial - {1'b0, w_den_i};
                        w_q_o[0] = 1'b1;
                    end
                    w_rem_o = trial[WIDTH-1:0];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_sb  <= '0;
                r_rem <= '0;
                r_q   <= '0;
                r_den <= '0;
            end else if (en) begin
                r_v   <= w_v_i;
                r_sb  <= w_sb_i;
                r_rem <= w_rem_o;
                r_q   <= w_q_o;
                r_den <= w_den_i;
            end
        end
    end

    logic w_unused;
    assign w_unused = ^{g_st[DIV_LAT-1].r_rem, g_st[DIV_LAT-1].r_den};

    assign out_valid = g_st[DIV_LAT-1].r_v;
    assign out_sb    = g_st[DIV_LAT-1].r_sb;
    assign out_quo   = g_st[DIV_LAT-1].r_q;

endmodule

// File: rtl/fx_inv_cdf_zs_pipe.sv
// Zelen & Severo inverse-normal stage: z = +/-(t - N(t)/D(t)), valid/ready stall-able.
// Optional input clamp of t to T_LIMIT is built when INVCDF_TCLAMP_EN is defined.
module fx_inv_cdf_zs_pipe
    import zs_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int QFRAC   = 16,
    parameter int DIV_LAT = 4,
    parameter int TAG_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_t,
    input  logic             in_negate,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic             clamp_sticky
);

    localparam int SB_W = 1 + TAG_W + WIDTH;

    localparam logic [WIDTH-1:0] K_ONE = WIDTH'(to_fx(1.0, QFRAC));
    localparam logic [WIDTH-1:0] K_C0  = WIDTH'(to_fx(C0, QFRAC));
    localparam logic [WIDTH-1:0] K_C1  = WIDTH'(to_fx(C1, QFRAC));
    localparam logic [WIDTH-1:0] K_C2  = WIDTH'(to_fx(C2, QFRAC));
    localparam logic [WIDTH-1:0] K_D1  = WIDTH'(to_fx(D1, QFRAC));
    localparam logic [WIDTH-1:0] K_D2  = WIDTH'(to_fx(D2, QFRAC));
    localparam logic [WIDTH-1:0] K_D3  = WIDTH'(to_fx(D3, QFRAC));

    function automatic logic [WIDTH-1:0] fx_mul(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [2*WIDTH-1:0] p;
        p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        return WIDTH'(p >>> QFRAC);
    endfunction

    logic             w_en;
    logic [WIDTH-1:0] w_t_in;
    zs_sb_t           w_sb_in;

    zs_sb_t           r_sb0, r_sb1, r_sb2, r_sb3;
    logic [WIDTH-1:0] r_t0, r_t1, r_t2, r_t3;
    logic [WIDTH-1:0] r_sq1, r_c1t1, r_d1t1;
    logic [WIDTH-1:0] r_cube2, r_num2, r_dp2;
    logic [WIDTH-1:0] r_num3, r_den3;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_z;
    logic [TAG_W-1:0] r_out_tag;

    // One global enable: every stage advances only when the output can move.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

`ifdef INVCDF_TCLAMP_EN
    localparam logic [WIDTH-1:0] K_TLIM = WIDTH'(to_fx(T_LIMIT_REAL, QFRAC));

    logic w_clamp;
    logic r_sticky;

    assign w_clamp = in_t[WIDTH-1] || (in_t > K_TLIM);
    assign w_t_in  = w_clamp ? K_TLIM : in_t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_en && in_valid && w_clamp) begin
            r_sticky <= 1'b1;
        end
    end

    assign clamp_sticky = r_sticky;
`else
    assign w_t_in       = in_t;
    assign clamp_sticky = 1'b0;
`endif

    always_comb begin
        w_sb_in        = '0;
        w_sb_in.valid  = in_valid;
        w_sb_in.negate = in_negate;
        w_sb_in.tag    = TAG_MAX'(in_tag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb0   <= '0;
            r_sb1   <= '0;
            r_sb2   <= '0;
            r_sb3   <= '0;
            r_t0    <= '0;
            r_t1    <= '0;
            r_t2    <= '0;
            r_t3    <= '0;
            r_sq1   <= '0;
            r_c1t1  <= '0;
            r_d1t1  <= '0;
            r_cube2 <= '0;
            r_num2  <= '0;
            r_dp2   <= '0;
            r_num3  <= '0;
            r_den3  <= '0;
        end else if (w_en) begin
            r_sb0   <= w_sb_in;
            r_t0    <= w_t_in;

            r_sb1   <= r_sb0;
            r_t1    <= r_t0;
            r_sq1   <= fx_mul(r_t0, r_t0);
            r_c1t1  <= fx_mul(K_C1, r_t0);
            r_d1t1  <= fx_mul(K_D1, r_t0);

            r_sb2   <= r_sb1;
            r_t2    <= r_t1;
            r_cube2 <= fx_mul(r_sq1, r_t1);
            r_num2  <= K_C0 + r_c1t1 + fx_mul(K_C2, r_sq1);
            r_dp2   <= K_ONE + r_d1t1 + fx_mul(K_D2, r_sq1);

            r_sb3   <= r_sb2;
            r_t3    <= r_t2;
            r_num3  <= r_num2;
            r_den3  <= r_dp2 + fx_mul(K_D3, r_cube2);
        end
    end

    logic             w_dv_valid;
    logic [SB_W-1:0]  w_dv_sb_in;
    logic [SB_W-1:0]  w_dv_sb;
    logic [WIDTH-1:0] w_dv_quo;

    // t rides in the divider sideband so y = t - ratio needs no delay line.
    assign w_dv_sb_in = {r_sb3.negate, r_sb3.tag[TAG_W-1:0], r_t3};

    zs_div_pipe #(
        .WIDTH   (WIDTH),
        .QFRAC   (QFRAC),
        .DIV_LAT (DIV_LAT),
        .SB_W    (SB_W)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_en),
        .in_valid  (r_sb3.valid),
        .in_sb     (w_dv_sb_in),
        .in_num    (r_num3),
        .in_den    (r_den3),
        .out_valid (w_dv_valid),
        .out_sb    (w_dv_sb),
        .out_quo   (w_dv_quo)
    );

    logic             w_dv_neg;
    logic [TAG_W-1:0] w_dv_tag;
    logic [WIDTH-1:0] w_dv_t;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_z;

    assign w_dv_neg = w_dv_sb[SB_W-1];
    assign w_dv_tag = w_dv_sb[WIDTH +: TAG_W];
    assign w_dv_t   = w_dv_sb[WIDTH-1:0];
    assign w_y      = w_dv_t - w_dv_quo;
    assign w_z      = w_dv_neg ? -w_y : w_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_z     <= '0;
            r_out_tag   <= '0;
        end else if (w_en) begin
            r_out_valid <= w_dv_valid;
            if (w_dv_valid) begin
                r_out_z   <= w_z;
                r_out_tag <= w_dv_tag;
            end
        end
    end

    logic w_unused;
    assign w_unused = ^r_sb3.tag;

    assign out_valid = r_out_valid;
    assign out_z     = r_out_z;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_fx_inv_cdf_zs_pipe.sv
// Self-checking bench for fx_inv_cdf_zs_pipe against a plain-arithmetic model.
// Clamp checks follow INVCDF_TCLAMP_EN.
module tb_fx_inv_cdf_zs_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_t = '0;
    logic        in_negate = 1'b0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_z;
    logic [7:0]  out_tag;
    logic        clamp_sticky;

    always #5 clk = ~clk;

    fx_inv_cdf_zs_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_t         (in_t),
        .in_negate    (in_negate),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_tag      (out_tag),
        .clamp_sticky (clamp_sticky)
    );

    localparam logic [31:0] BONE = 32'h0001_0000;
    localparam logic [31:0] BC0  = 32'(longint'(2.515517 * 65536.0));
    localparam logic [31:0] BC1  = 32'(longint'(0.802853 * 65536.0));
    localparam logic [31:0] BC2  = 32'(longint'(0.010328 * 65536.0));
    localparam logic [31:0] BD1  = 32'(longint'(1.432788 * 65536.0));
    localparam logic [31:0] BD2  = 32'(longint'(0.189269 * 65536.0));
    localparam logic [31:0] BD3  = 32'(longint'(0.001308 * 65536.0));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] q_exp_z[$];
    logic [7:0]  q_exp_tag[$];
    logic [31:0] q_obs_z[$];
    logic [7:0]  q_obs_tag[$];
    int          q_obs_cyc[$];

    function automatic logic [31:0] fxm(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[47:16];
    endfunction

    function automatic logic [31:0] ref_z(input logic [31:0] tin, input logic neg);
        logic [31:0]     t, t2, t3, num, den, ratio, y;
        longint unsigned dvd;
        t = tin;
`ifdef INVCDF_TCLAMP_EN
        if ($signed(tin) < 0 || $signed(tin) > 32'sh0008_0000) t = 32'h0008_0000;
`endif
        t2    = fxm(t, t);
        t3    = fxm(t2, t);
        num   = BC0 + fxm(BC1, t) + fxm(BC2, t2);
        den   = BONE + fxm(BD1, t) + fxm(BD2, t2) + fxm(BD3, t3);
        dvd   = {32'h0, num} << 16;
        ratio = 32'(dvd / {32'h0, den});
        y     = t - ratio;
        return neg ? -y : y;
    endfunction

    // Records accepts and output handshakes for the coming edge, then advances one cycle.
    task automatic step();
        #1;
        if (in_valid && in_ready) begin
            q_exp_z.push_back(ref_z(in_t, in_negate));
            q_exp_tag.push_back(in_tag);
        end
        if (out_valid && out_ready) begin
            q_obs_z.push_back(out_z);
            q_obs_tag.push_back(out_tag);
            q_obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_q();
        q_exp_z.delete();
        q_exp_tag.delete();
        q_obs_z.delete();
        q_obs_tag.delete();
        q_obs_cyc.delete();
    endtask

    task automatic new_word();
        in_t      = $urandom_range(0, 32'h0007_FFFF);
        in_negate = 1'($urandom_range(0, 1));
        in_tag    = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (out_z !== 32'h0 || out_tag !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_data: got z=%h tag=%h want 0/0", out_z, out_tag);
        end
        n_checks++;
        if (clamp_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sticky: got %b want 0", clamp_sticky);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_one_point();
        int lat;
        int z;
        int zref;
        clear_q();
        zref      = int'(-0.268864 * 65536.0);
        in_t      = 32'h0001_0000;
        in_negate = 1'b0;
        in_tag    = 8'h5A;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        n_checks++;
        if (lat != 9) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles want 9", lat);
        end
        n_checks++;
        if (out_tag !== 8'h5A) begin
            n_fail++;
            $display("FAIL t1_tag: got %h want 5a", out_tag);
        end
        z = $signed(out_z);
        n_checks++;
        if (z < zref - 4 || z > zref + 4) begin
            n_fail++;
            $display("FAIL t1_approx: got %0d want %0d +/-4", z, zref);
        end
        n_checks++;
        if (out_z !== ref_z(32'h0001_0000, 1'b0)) begin
            n_fail++;
            $display("FAIL t1_exact: got %h want %h", out_z, ref_z(32'h0001_0000, 1'b0));
        end
        step();
    endtask

    task automatic test_p025();
        int          lat;
        int          z;
        int          zref;
        logic [31:0] t;
        clear_q();
        t         = 32'(longint'(2.716203 * 65536.0));
        zref      = $signed(32'hFFFE_0A40);
        in_t      = t;
        in_negate = 1'b1;
        in_tag    = 8'hC3;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL p025_timeout: no result within %0d cycles", lat);
        end
        z = $signed(out_z);
        n_checks++;
        if (z < zref - 40 || z > zref + 40) begin
            n_fail++;
            $display("FAIL p025_approx: got %0d want %0d +/-40", z, zref);
        end
        n_checks++;
        if (out_z !== ref_z(t, 1'b1) || out_tag !== 8'hC3) begin
            n_fail++;
            $display("FAIL p025_exact: got %h/%h want %h/c3", out_z, out_tag, ref_z(t, 1'b1));
        end
        step();
    endtask

    task automatic test_back_to_back();
        int b;
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            new_word();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        b = 0;
        while (q_obs_z.size() < q_exp_z.size() && b < 100) begin
            step();
            b++;
        end
        n_checks++;
        if (q_exp_z.size() != 1000 || q_obs_z.size() != 1000) begin
            n_fail++;
            $display("FAIL b2b_count: accepted %0d returned %0d want 1000", q_exp_z.size(), q_obs_z.size());
        end
        for (int i = 0; i < q_obs_z.size() && i < q_exp_z.size(); i++) begin
            n_checks++;
            if (q_obs_z[i] !== q_exp_z[i] || q_obs_tag[i] !== q_exp_tag[i]) begin
                n_fail++;
                $display("FAIL b2b_word %0d: got %h/%h want %h/%h", i, q_obs_z[i], q_obs_tag[i], q_exp_z[i], q_exp_tag[i]);
            end
        end
        if (q_obs_cyc.size() == 1000) begin
            n_checks++;
            if (q_obs_cyc[999] - q_obs_cyc[0] != 999) begin
                n_fail++;
                $display("FAIL b2b_rate: 1000 results over %0d cycles want 1000", q_obs_cyc[999] - q_obs_cyc[0] + 1);
            end
        end
    endtask

    task automatic test_stall();
        int          sent;
        int          b;
        int          n;
        logic [31:0] hz;
        logic [7:0]  ht;
        clear_q();
        sent = 0;
        hz   = '0;
        ht   = '0;
        new_word();
        in_valid = 1'b1;
        for (int c = 0; c < 200 && sent < 60; c++) begin
            out_ready = !(c >= 25 && c < 45);
            if (c == 25) begin
                hz = out_z;
                ht = out_tag;
            end
            if (c > 25 && c < 45) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_ready c%0d: got %b want 0", c, in_ready);
                end
                n_checks++;
                if (out_valid !== 1'b1 || out_z !== hz || out_tag !== ht) begin
                    n_fail++;
                    $display("FAIL stall_hold c%0d: got %b %h/%h want 1 %h/%h", c, out_valid, out_z, out_tag, hz, ht);
                end
            end
            n = q_exp_z.size();
            step();
            if (q_exp_z.size() > n) begin
                sent++;
                new_word();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        b = 0;
        while (q_obs_z.size() < q_exp_z.size() && b < 100) begin
            step();
            b++;
        end
        n_checks++;
        if (q_exp_z.size() != 60 || q_obs_z.size() != 60) begin
            n_fail++;
            $display("FAIL stall_count: accepted %0d returned %0d want 60", q_exp_z.size(), q_obs_z.size());
        end
        for (int i = 0; i < q_obs_z.size() && i < q_exp_z.size(); i++) begin
            n_checks++;
            if (q_obs_z[i] !== q_exp_z[i] || q_obs_tag[i] !== q_exp_tag[i]) begin
                n_fail++;
                $display("FAIL stall_word %0d: got %h/%h want %h/%h", i, q_obs_z[i], q_obs_tag[i], q_exp_z[i], q_exp_tag[i]);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            new_word();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got out_valid %b want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_z !== 32'h0 || out_tag !== 8'h0) begin
            n_fail++;
            $display("FAIL rst_async: got %b %h/%h want 0 0/0", out_valid, out_z, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
        repeat (30) step();
        n_checks++;
        if (q_obs_z.size() != 0) begin
            n_fail++;
            $display("FAIL rst_stale: got %0d results want 0", q_obs_z.size());
        end
    endtask

    task automatic test_clamp();
        int b;
        clear_q();
        out_ready = 1'b1;
        n_checks++;
        if (clamp_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_pre: got %b want 0", clamp_sticky);
        end
        in_valid  = 1'b1;
        in_t      = 32'h0010_0000;
        in_negate = 1'b0;
        in_tag    = 8'h11;
        step();
        in_t      = 32'h8000_0000;
        in_negate = 1'b1;
        in_tag    = 8'h22;
        step();
        in_valid = 1'b0;
        b = 0;
        while (q_obs_z.size() < 2 && b < 40) begin
            step();
            b++;
        end
        n_checks++;
        if (q_obs_z.size() != 2) begin
            n_fail++;
            $display("FAIL clamp_count: got %0d results want 2", q_obs_z.size());
        end
`ifdef INVCDF_TCLAMP_EN
        if (q_obs_z.size() == 2) begin
            n_checks++;
            if (q_obs_z[0] !== ref_z(32'h0008_0000, 1'b0)) begin
                n_fail++;
                $display("FAIL clamp_16: got %h want %h", q_obs_z[0], ref_z(32'h0008_0000, 1'b0));
            end
            n_checks++;
            if (q_obs_z[1] !== ref_z(32'h0008_0000, 1'b1)) begin
                n_fail++;
                $display("FAIL clamp_neg: got %h want %h", q_obs_z[1], ref_z(32'h0008_0000, 1'b1));
            end
        end
        n_checks++;
        if (clamp_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_sticky: got %b want 1", clamp_sticky);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (clamp_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_clear: got %b want 0", clamp_sticky);
        end
        rst_n = 1'b1;
        @(negedge clk);
`else
        n_checks++;
        if (clamp_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_tied: got %b want 0", clamp_sticky);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_one_point();
        test_p025();
        test_back_to_back();
        test_stall();
        test_reset_in_flight();
        test_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
